// File: rtl/apb_csr_master.sv
// APB3 requester for the CSR bank: one command at a time, SETUP/ACCESS sequencing,
// PREADY wait with a bounded wait-state timeout, one-cycle response pulse.
module apb_csr_master #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [DATA_WIDTH-1:0] o_pwdata,
  input  logic [DATA_WIDTH-1:0] i_prdata,
  input  logic                  i_pready,
  input  logic                  i_pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // Encoding chosen so bit 1 is PSEL and bit 0 is PENABLE straight from the flops.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETUP  = 2'b10,
    S_ACCESS = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  // Next-state, command capture and completion logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          state_d  = S_SETUP;
          cnt_d    = '0;
          paddr_d  = i_cmd_addr;
          pwrite_d = i_cmd_write;
          pwdata_d = i_cmd_write ? i_cmd_wdata : '0;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (i_pready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = i_pslverr;
          rsp_rdata_d = pwrite_q ? '0 : i_prdata;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_psel      = state_q[1];
  assign o_penable   = state_q[0];
  assign o_cmd_ready = ~state_q[1];
  assign o_paddr     = paddr_q;
  assign o_pwrite    = pwrite_q;
  assign o_pwdata    = pwdata_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_csr_master.sv
// Bench for apb_csr_master: a per-cycle expectation schedule built from the latency
// rules, checked every cycle, plus directed literal checks of the key scenarios.
module tb_apb_csr_master;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned TO   = 16;
  localparam int          NCYC = 12000;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_write = 1'b0;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [DW-1:0] i_cmd_wdata = '0;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_paddr;
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [DW-1:0] o_pwdata;
  logic [DW-1:0] i_prdata = '0;
  logic          i_pready = 1'b0;
  logic          i_pslverr = 1'b0;

  apb_csr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_paddr(o_paddr), .o_psel(o_psel), .o_penable(o_penable),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata),
    .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
  );

  always #5 i_clk = ~i_clk;

  // Cycle k is the interval after the k-th rising edge.
  int cyc = 0;
  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour per cycle; unset cycles mean idle bus, no response.
  bit            e_psel  [NCYC];
  bit            e_pen   [NCYC];
  bit            e_rsp   [NCYC];
  bit            e_rst   [NCYC];
  logic [AW-1:0] e_paddr [NCYC];
  bit            e_pwrite[NCYC];
  logic [DW-1:0] e_pwdata[NCYC];
  logic [DW-1:0] e_rdata [NCYC];
  bit            e_err   [NCYC];

  logic [DW-1:0] h_rdata = '0;
  bit            h_err   = 1'b0;
  int pen_run = 0, last_pen = -1, idle_run = 0, last_gap = -1, rsp_cyc = -1;
  bit prev_psel = 1'b0;
  int t0 = 0;

  // Per-cycle compare against the schedule, plus run-length monitors.
  initial forever begin
    @(negedge i_clk);
    if (cyc >= 1 && cyc < NCYC) begin
      if (e_rst[cyc]) begin h_rdata = '0; h_err = 1'b0; end
      if (e_rsp[cyc]) begin h_rdata = e_rdata[cyc]; h_err = e_err[cyc]; end
      chk("psel", o_psel, e_psel[cyc]);
      chk("penable", o_penable, e_pen[cyc]);
      chk("cmd_ready", o_cmd_ready, !e_psel[cyc]);
      chk("rsp_valid", o_rsp_valid, e_rsp[cyc]);
      chk("rsp_rdata", o_rsp_rdata, h_rdata);
      chk("rsp_err", o_rsp_err, h_err);
      if (e_psel[cyc]) begin
        chk("paddr", o_paddr, e_paddr[cyc]);
        chk("pwrite", o_pwrite, e_pwrite[cyc]);
        chk("pwdata", o_pwdata, e_pwdata[cyc]);
      end
      if (o_psel && !prev_psel) begin last_gap = idle_run; pen_run = 0; end
      if (!o_psel) idle_run++; else idle_run = 0;
      if (o_penable) pen_run++;
      if (o_rsp_valid) begin last_pen = pen_run; rsp_cyc = cyc; end
      prev_psel = o_psel;
    end
  end

  task automatic rand_slave();
    i_pready  = 1'($urandom);
    i_pslverr = 1'($urandom);
    i_prdata  = DW'($urandom);
  endtask

  // One transfer: w wait states (w >= TO means timeout), optional busy valid,
  // optional reset at ACCESS cycle index rst_at. Returns in the response cycle.
  task automatic run(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input int w, input bit slv, input logic [DW-1:0] prd,
                     input bit busy, input int rst_at);
    int  k, a, rsp, j;
    bit  to;
    k   = cyc;
    t0  = k;
    to  = (w >= int'(TO));
    a   = to ? int'(TO) : w + 1;
    rsp = k + 2 + a;
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    for (int c = k + 1; c <= k + 1 + a; c++) begin
      e_psel[c]   = 1'b1;
      e_pen[c]    = (c >= k + 2);
      e_paddr[c]  = addr;
      e_pwrite[c] = wr;
      e_pwdata[c] = wr ? wd : '0;
    end
    e_rsp[rsp]   = 1'b1;
    e_err[rsp]   = to ? 1'b1 : slv;
    e_rdata[rsp] = (wr || to) ? '0 : prd;
    for (int c = k + 1; c <= rsp; c++) begin
      @(posedge i_clk); #1;
      i_cmd_valid = busy && (c < rsp);
      i_cmd_write = 1'($urandom);
      i_cmd_addr  = AW'($urandom);
      i_cmd_wdata = DW'($urandom);
      if (c >= k + 2 && c <= k + 1 + a) begin
        j = c - k - 2;
        i_pready  = (j == w);
        i_pslverr = (j == w) ? slv : 1'($urandom);
        i_prdata  = (j == w) ? prd : DW'($urandom);
        if (j == rst_at) begin
          i_rst_n = 1'b0;
          for (int q = c + 1; q <= rsp; q++) begin
            e_psel[q] = 1'b0; e_pen[q] = 1'b0; e_rsp[q] = 1'b0;
          end
          e_rst[c + 1] = 1'b1;
          @(posedge i_clk); #1;
          i_rst_n     = 1'b1;
          i_cmd_valid = 1'b0;
          return;
        end
      end else begin
        rand_slave();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      i_cmd_valid = 1'b0;
      rand_slave();
    end
  endtask

  task automatic settle();
    @(negedge i_clk); #1;
  endtask

  initial begin
    int w, rst_at;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    chk("reset_ready", o_cmd_ready, 1);
    chk("reset_psel", o_psel, 0);
    chk("reset_paddr", o_paddr, 0);
    chk("reset_pwdata", o_pwdata, 0);
    chk("reset_rsp", {o_rsp_valid, o_rsp_err, o_rsp_rdata}, 0);

    run(1'b1, 8'h03, 8'hA5, 0, 1'b0, 8'h77, 1'b0, -1);
    chk("wr0_rsp_valid", o_rsp_valid, 1);
    chk("wr0_err_rdata", {o_rsp_err, o_rsp_rdata}, 0);
    settle();
    chk("wr0_latency", rsp_cyc - t0, 3);
    chk("wr0_pen_cycles", last_pen, 1);

    idle(1);
    run(1'b0, 8'h01, 8'hEE, 2, 1'b0, 8'h5C, 1'b0, -1);
    settle();
    chk("rd2_rdata", o_rsp_rdata, 8'h5C);
    chk("rd2_err", o_rsp_err, 0);
    chk("rd2_latency", rsp_cyc - t0, 5);
    chk("rd2_pen_cycles", last_pen, 3);

    idle(1);
    run(1'b0, 8'h07, 8'h00, 0, 1'b1, 8'h11, 1'b0, -1);
    settle();
    chk("slverr_err", o_rsp_err, 1);
    chk("slverr_rdata", o_rsp_rdata, 8'h11);

    run(1'b0, 8'h02, 8'h00, 100, 1'b0, 8'h33, 1'b0, -1);
    settle();
    chk("timeout_pen_cycles", last_pen, 16);
    chk("timeout_err_rdata", {o_rsp_err, o_rsp_rdata}, 9'h100);
    chk("timeout_ready", o_cmd_ready, 1);
    chk("timeout_psel", o_psel, 0);

    run(1'b0, 8'h04, 8'h00, int'(TO) - 1, 1'b0, 8'h9A, 1'b0, -1);
    settle();
    chk("lastwait_pen_cycles", last_pen, 16);
    chk("lastwait_err_rdata", {o_rsp_err, o_rsp_rdata}, 9'h09A);

    idle(2);
    run(1'b1, 8'h10, 8'h3C, 1, 1'b0, 8'h00, 1'b1, -1);
    run(1'b0, 8'h11, 8'h00, 0, 1'b0, 8'hC3, 1'b1, -1);
    settle();
    chk("b2b_gap", last_gap, 1);
    chk("b2b_rdata", o_rsp_rdata, 8'hC3);

    idle(1);
    run(1'b0, 8'h20, 8'h00, 5, 1'b0, 8'h44, 1'b0, 2);
    chk("rst_psel_pen", {o_psel, o_penable}, 0);
    chk("rst_rsp", {o_rsp_valid, o_rsp_err, o_rsp_rdata}, 0);
    chk("rst_apb", {o_paddr, o_pwrite, o_pwdata}, 0);
    chk("rst_ready", o_cmd_ready, 1);

    for (int n = 0; n < 250; n++) begin
      idle(int'($urandom_range(0, 2)));
      case ($urandom_range(0, 9))
        0:       w = int'($urandom_range(TO - 2, TO + 3));
        1, 2:    w = int'($urandom_range(4, 10));
        default: w = int'($urandom_range(0, 3));
      endcase
      rst_at = -1;
      if ($urandom_range(0, 24) == 0) rst_at = int'($urandom_range(0, (w < int'(TO)) ? w : int'(TO) - 1));
      if (rst_at == w) rst_at = -1;
      run(1'($urandom), AW'($urandom), DW'($urandom), w, 1'($urandom), DW'($urandom),
          1'($urandom), rst_at);
    end
    idle(4);
    settle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_csr_master.md
Name: apb_csr_master

Overview:
- APB3 requester that drives the CSR register bank's APB completer port.
- Accepts single read/write commands on a valid/ready interface from local control logic (sequencer or bring-up bench).
- Runs APB SETUP/ACCESS phases, waits for PREADY, and returns read data and error status as a one-cycle response pulse.
- Bounds every access with a wait-state timeout so a hung completer cannot stall the requester.

Parameters:
ADDR_WIDTH, 8, width of command address and PADDR
DATA_WIDTH, 8, width of write/read data and PWDATA/PRDATA
TIMEOUT, 16, max ACCESS-phase cycles before forced error completion (>=1)

Ports:
i_clk  in  1  clock; all state on rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  requester idle, command accepted when valid&ready
i_cmd_write  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_WIDTH  target register address
i_cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
o_rsp_valid  out  1  one-cycle completion pulse
o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
o_rsp_err  out  1  PSLVERR or timeout on this transfer
o_paddr  out  ADDR_WIDTH  APB PADDR
o_psel  out  1  APB PSEL
o_penable  out  1  APB PENABLE
o_pwrite  out  1  APB PWRITE
o_pwdata  out  DATA_WIDTH  APB PWDATA
i_prdata  in  DATA_WIDTH  APB PRDATA
i_pready  in  1  APB PREADY
i_pslverr  in  1  APB PSLVERR

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE. o_psel=0, o_penable=0, o_pwrite=0, o_paddr=0, o_pwdata=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, timeout counter=0.
- Reset mid-transfer aborts immediately: no response pulse, APB signals return to 0 on that edge.
- FSM states and transitions:
  - IDLE: o_cmd_ready=1; psel=penable=0. On valid&ready, register write/addr/wdata and go to SETUP. pwdata is forced to 0 for reads.
  - SETUP, one cycle: psel=1, penable=0, paddr/pwrite/pwdata = registered command; go to ACCESS.
  - ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
    - If i_pready=1: complete and go to IDLE.
    - Else increment counter; when counter reaches TIMEOUT-1 with pready still 0, force completion with err=1 and go to IDLE.
- o_cmd_ready is 0 in SETUP and ACCESS. i_cmd_valid in those states is ignored; no queuing.
- Completion (registered, visible the cycle after the completing ACCESS edge):
  - o_rsp_valid=1 for exactly one cycle.
  - o_rsp_err = i_pslverr (normal) or 1 (timeout).
  - o_rsp_rdata = i_prdata for a read with pready=1; 0 for writes and timeouts. PRDATA is captured even when PSLVERR=1.
  - rdata/err hold their value until the next completion.
- In the response cycle the FSM is already IDLE: a new command may be accepted in the same cycle o_rsp_valid=1.
- No back-to-back transfers: psel is deasserted for at least one cycle (IDLE) between transfers.
- Latency:
  - Accept edge T0; SETUP in cycle T0+1; first ACCESS in T0+2.
  - pready=1 there gives o_rsp_valid in T0+3; each wait state adds one cycle.
- Timeout counter clears on entry to SETUP. PSLVERR is sampled only when pready=1. i_pready/i_pslverr outside ACCESS are ignored.

Test Plan:
- Write, zero wait states:
  - Stimulus: cmd write addr=0x03 wdata=0xA5, pready=1 on first ACCESS.
  - Required: SETUP then ACCESS with paddr=0x03, pwrite=1, pwdata=0xA5; o_rsp_valid pulse at T0+3 with err=0, rdata=0x00.
- Read, 2 wait states:
  - Stimulus: cmd read addr=0x01, completer drives pready=0,0,1 with prdata=0x5C.
  - Required: penable high 3 cycles, addr stable throughout; rsp at T0+5 with rdata=0x5C, err=0.
- Slave error:
  - Stimulus: read addr=0x07, pready=1 with pslverr=1 and prdata=0x11.
  - Required: rsp err=1, rdata=0x11; next command accepted normally.
- Timeout:
  - Stimulus: TIMEOUT=16, pready held 0.
  - Required: penable high exactly 16 cycles, then psel=0; rsp err=1, rdata=0x00; o_cmd_ready returns to 1.
- Busy and back-to-back:
  - Stimulus: i_cmd_valid held 1 throughout SETUP/ACCESS.
  - Required: o_cmd_ready=0 during the transfer; second command accepted in the rsp_valid cycle; psel low for exactly one cycle between transfers.
- Reset mid-ACCESS:
  - Stimulus: i_rst_n=0 for one edge during a wait state.
  - Required: psel=penable=0 next cycle, no rsp pulse, all outputs 0, o_cmd_ready=1 after reset release.
